// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, R/W values and default address.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_RX       = 3'd3,
        ST_RX_ACK   = 3'd4,
        ST_TX       = 3'd5,
        ST_TX_ACK   = 3'd6,
        ST_IGNORE   = 3'd7
    } i2c_state_e;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam logic [6:0] DEF_ADDRESS = 7'h77;

endpackage

// File: rtl/i2c_slave_if.sv
// Bus pins and user-side byte handshake of the I2C target.
interface i2c_slave_if;

    logic       sclk;
    logic       sda_in;
    logic       sda_out;
    logic [7:0] tx_data;
    logic       tx_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic [2:0] state;

    modport slave (
        input  sclk, sda_in, tx_data,
        output sda_out, tx_req, rx_data, rx_valid, busy, state
    );

    modport master (
        output sclk, sda_in, tx_data,
        input  sda_out, tx_req, rx_data, rx_valid, busy, state
    );

endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronizes raw SCL/SDA and produces edge, START and STOP strobes.
module i2c_bus_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start_det,
    output logic stop_det
);

    logic [2:0] scl_q;
    logic [2:0] sda_q;
    logic       scl_hi;

    // SCL counts as high only when stable across both compared samples
    assign scl_hi = scl_q[1] & scl_q[2];
    assign sda_s  = sda_q[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_q     <= 3'b111;
            sda_q     <= 3'b111;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            scl_q     <= {scl_q[1:0], scl_in};
            sda_q     <= {sda_q[1:0], sda_in};
            scl_rise  <= scl_q[1] & ~scl_q[2];
            scl_fall  <= ~scl_q[1] & scl_q[2];
            start_det <= scl_hi & sda_q[2] & ~sda_q[1];
            stop_det  <= scl_hi & ~sda_q[2] & sda_q[1];
        end
    end

endmodule

// File: rtl/i2c_slave.sv
// I2C target: address match, write reception and read byte serving.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDRESS = DEF_ADDRESS
) (
    input logic        clk,
    input logic        rst,
    i2c_slave_if.slave bus
);

    logic       scl_rise;
    logic       scl_fall;
    logic       sda_s;
    logic       start_det;
    logic       stop_det;

    i2c_state_e st;
    logic [2:0] cnt;
    logic [7:0] sh;
    logic       rw;
    logic       phase;

    i2c_bus_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (bus.sclk),
        .sda_in    (bus.sda_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .sda_s     (sda_s),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign bus.state = st;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st           <= ST_IDLE;
            cnt          <= 3'd0;
            sh           <= 8'h00;
            rw           <= RW_WRITE;
            phase        <= 1'b0;
            bus.sda_out  <= 1'b1;
            bus.tx_req   <= 1'b0;
            bus.rx_valid <= 1'b0;
            bus.rx_data  <= 8'h00;
            bus.busy     <= 1'b0;
        end else begin
            bus.tx_req   <= 1'b0;
            bus.rx_valid <= 1'b0;
            if (start_det) begin
                st          <= ST_ADDR;
                cnt         <= 3'd0;
                phase       <= 1'b0;
                bus.sda_out <= 1'b1;
                bus.busy    <= 1'b0;
            end else if (stop_det) begin
                st          <= ST_IDLE;
                cnt         <= 3'd0;
                phase       <= 1'b0;
                bus.sda_out <= 1'b1;
                bus.busy    <= 1'b0;
            end else begin
                unique case (st)
                    ST_IDLE: ;
                    ST_ADDR: if (scl_rise) begin
                        sh  <= {sh[6:0], sda_s};
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            if (sh[6:0] == ADDRESS) begin
                                st       <= ST_ADDR_ACK;
                                rw       <= sda_s;
                                bus.busy <= 1'b1;
                                phase    <= 1'b0;
                            end else begin
                                st          <= ST_IGNORE;
                                bus.sda_out <= 1'b1;
                            end
                        end
                    end
                    ST_ADDR_ACK: if (scl_fall) begin
                        if (!phase) begin
                            bus.sda_out <= 1'b0;
                            phase       <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            cnt   <= 3'd0;
                            if (rw == RW_READ) begin
                                sh          <= bus.tx_data;
                                bus.tx_req  <= 1'b1;
                                bus.sda_out <= bus.tx_data[7];
                                st          <= ST_TX;
                            end else begin
                                bus.sda_out <= 1'b1;
                                st          <= ST_RX;
                            end
                        end
                    end
                    ST_RX: if (scl_rise) begin
                        sh  <= {sh[6:0], sda_s};
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            bus.rx_data  <= {sh[6:0], sda_s};
                            bus.rx_valid <= 1'b1;
                            st           <= ST_RX_ACK;
                            phase        <= 1'b0;
                        end
                    end
                    ST_RX_ACK: if (scl_fall) begin
                        if (!phase) begin
                            bus.sda_out <= 1'b0;
                            phase       <= 1'b1;
                        end else begin
                            bus.sda_out <= 1'b1;
                            phase       <= 1'b0;
                            cnt         <= 3'd0;
                            st          <= ST_RX;
                        end
                    end
                    // phase marks that all 8 bits have been clocked out
                    ST_TX: begin
                        if (scl_fall) begin
                            if (phase) begin
                                bus.sda_out <= 1'b1;
                                phase       <= 1'b0;
                                st          <= ST_TX_ACK;
                            end else begin
                                sh          <= {sh[6:0], 1'b0};
                                bus.sda_out <= sh[6];
                            end
                        end else if (scl_rise) begin
                            cnt <= cnt + 3'd1;
                            if (cnt == 3'd7) phase <= 1'b1;
                        end
                    end
                    ST_TX_ACK: begin
                        if (scl_rise && !phase) begin
                            if (sda_s) begin
                                st          <= ST_IGNORE;
                                bus.busy    <= 1'b0;
                                bus.sda_out <= 1'b1;
                            end else begin
                                phase <= 1'b1;
                            end
                        end else if (scl_fall && phase) begin
                            phase       <= 1'b0;
                            cnt         <= 3'd0;
                            sh          <= bus.tx_data;
                            bus.tx_req  <= 1'b1;
                            bus.sda_out <= bus.tx_data[7];
                            st          <= ST_TX;
                        end
                    end
                    ST_IGNORE: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Bit-banged I2C master bench with scoreboard queues for rx/tx byte events.
module tb_i2c_slave;
    import i2c_pkg::*;

    localparam int Q = 6;
    localparam logic [6:0] TGT = 7'h77;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl = 1'b1;
    logic sda_m = 1'b1;

    i2c_slave_if bus ();

    assign bus.sclk   = scl;
    assign bus.sda_in = sda_m & bus.sda_out;

    i2c_slave #(.ADDRESS(TGT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    bit chk_rel = 1'b0;
    int rel_viol = 0;
    logic [7:0] last_rx = 8'h00;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rx_valid) begin
                if (rxq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_valid unexpected: got %0h want none",
                             bus.rx_data);
                end else begin
                    chk("rx_data", bus.rx_data, rxq.pop_front());
                end
            end
            if (bus.tx_req) begin
                if (txq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_req unexpected: got %0h want none",
                             bus.tx_data);
                end else begin
                    chk("tx_req byte", bus.tx_data, txq.pop_front());
                end
            end
            if (chk_rel && bus.sda_out !== 1'b1) rel_viol++;
        end
    end

    task automatic w(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic bit_out(input logic b);
        sda_m = b;
        w(Q); scl = 1'b1;
        w(2 * Q); scl = 1'b0;
        w(Q);
    endtask

    task automatic bit_in(output logic b);
        sda_m = 1'b1;
        w(Q); scl = 1'b1;
        w(Q); #1 b = bus.sda_in;
        w(Q); scl = 1'b0;
        w(Q);
    endtask

    task automatic start_c();
        sda_m = 1'b1;
        w(Q); scl = 1'b1;
        w(Q); sda_m = 1'b0;
        w(Q); scl = 1'b0;
        w(Q);
    endtask

    task automatic stop_c();
        sda_m = 1'b0;
        w(Q); scl = 1'b1;
        w(Q); sda_m = 1'b1;
        w(2 * Q);
    endtask

    task automatic send_byte(input logic [7:0] v, input logic exp_ack,
                             input string nm);
        logic a;
        for (int i = 7; i >= 0; i--) bit_out(v[i]);
        bit_in(a);
        chk(nm, a, exp_ack);
    endtask

    task automatic read_byte(input logic [7:0] exp, input string nm);
        logic [7:0] v;
        logic b;
        for (int i = 0; i < 8; i++) begin
            bit_in(b);
            v = {v[6:0], b};
        end
        chk(nm, v, exp);
    endtask

    // Reference: address hit is decided only by the upper 7 bits
    task automatic xfer(input logic [7:0] ab, input logic [7:0] d[$],
                        input bit stop_after);
        bit hit;
        bit rd;
        hit = (ab[7:1] == TGT);
        rd  = hit && (ab[0] == RW_READ);
        if (rd) begin
            bus.tx_data = d[0];
            foreach (d[i]) txq.push_back(d[i]);
        end
        start_c();
        chk_rel  = !hit;
        rel_viol = 0;
        send_byte(ab, !hit, "addr ack");
        #1 chk("busy after addr", bus.busy, hit);
        if (rd) begin
            for (int i = 0; i < d.size(); i++) begin
                read_byte(d[i], "read byte");
                if (i < d.size() - 1) begin
                    bus.tx_data = d[i + 1];
                    bit_out(1'b0);
                end else begin
                    bit_out(1'b1);
                end
            end
            #1 chk("state after nack", bus.state, ST_IGNORE);
            chk("busy after nack", bus.busy, 1'b0);
        end else begin
            foreach (d[i]) begin
                if (hit) begin
                    rxq.push_back(d[i]);
                    last_rx = d[i];
                end
                send_byte(d[i], !hit, "data ack");
            end
            if (!hit) begin
                #1 chk("state ignore", bus.state, ST_IGNORE);
            end
        end
        if (stop_after) begin
            stop_c();
            #1 chk("state after stop", bus.state, ST_IDLE);
            chk("busy after stop", bus.busy, 1'b0);
            chk("sda_out after stop", bus.sda_out, 1'b1);
            if (chk_rel) chk("sda held released", rel_viol, 0);
            chk_rel = 1'b0;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] d[$];
        logic a;
        logic [6:0] ra;
        int n;
        bus.tx_data = 8'h00;
        w(3);
        #1;
        chk("rst sda_out", bus.sda_out, 1'b1);
        chk("rst tx_req", bus.tx_req, 1'b0);
        chk("rst rx_valid", bus.rx_valid, 1'b0);
        chk("rst rx_data", bus.rx_data, 8'h00);
        chk("rst busy", bus.busy, 1'b0);
        chk("rst state", bus.state, ST_IDLE);
        @(negedge clk) rst = 1'b0;
        w(4);

        d = {8'hA5};
        xfer(8'hEE, d, 1'b1);

        d = {8'h12};
        xfer(8'h50, d, 1'b1);

        d = {8'h3C, 8'h81};
        xfer(8'hEF, d, 1'b1);

        d = {8'h11};
        xfer(8'hEE, d, 1'b0);
        d = {8'h5A};
        xfer(8'hEF, d, 1'b1);
        chk("rx_data after rstart", bus.rx_data, 8'h11);

        start_c();
        send_byte(8'hEE, 1'b0, "addr ack partial");
        for (int i = 0; i < 4; i++) bit_out(1'($urandom_range(0, 1)));
        stop_c();
        #1 chk("partial state", bus.state, ST_IDLE);
        chk("partial sda_out", bus.sda_out, 1'b1);
        chk("partial rx_data", bus.rx_data, last_rx);

        start_c();
        for (int i = 7; i >= 0; i--) bit_out(1'(8'hEE >> i));
        sda_m = 1'b1;
        w(Q); scl = 1'b1;
        w(Q);
        #1 chk("ack driven pre-rst", bus.sda_out, 1'b0);
        rst = 1'b1;
        #1 chk("async rst sda_out", bus.sda_out, 1'b1);
        chk("async rst state", bus.state, ST_IDLE);
        last_rx = 8'h00;
        w(2);
        #1 rst = 1'b0;
        scl = 1'b0;
        w(Q);
        d = {8'h77};
        xfer(8'hEE, d, 1'b1);

        for (int t = 0; t < 8; t++) begin
            a = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) begin
                ra = TGT;
            end else begin
                ra = 7'($urandom_range(0, 127));
                if (ra == TGT) ra = 7'h12;
            end
            n = $urandom_range(1, 3);
            d = {};
            for (int i = 0; i < n; i++) d.push_back(8'($urandom));
            xfer({ra, a}, d, 1'b1);
        end

        w(10);
        chk("rx queue drained", rxq.size(), 0);
        chk("tx queue drained", txq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
